// File: rtl/rast_tri_fifo.sv
// rast_tri_fifo: first-word-fall-through triangle FIFO between raster stages.
// Holds DEPTH triangles (vertices + colour) with a valid/halt handshake on both sides.
// Optional macro RAST_TRI_CULL_EN: zero-area triangles are accepted but dropped,
// and culled_cnt_RnnnnU counts them (saturating). Without it the counter reads 0.
module rast_tri_fifo #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3,
  parameter int DEPTH  = 4
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R10S,
  input  logic        [COLORS-1:0][SIGFIG-1:0]          color_R10U,
  input  logic                                          validTri_R10H,
  output logic                                          halt_RnnnnL,
  output logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R11S,
  output logic        [COLORS-1:0][SIGFIG-1:0]          color_R11U,
  output logic                                          validTri_R11H,
  input  logic                                          halt_R11L,
  output logic        [$clog2(DEPTH+1)-1:0]             count_R11U,
  output logic        [15:0]                            culled_cnt_RnnnnU
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  typedef logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] vtx_set_t;
  typedef logic [COLORS-1:0][SIGFIG-1:0]          col_t;

  // Fraction position is carried for documentation of the fixed-point format only.
  logic [31:0] unused_radix;
  assign unused_radix = RADIX;

  vtx_set_t        tri_mem [DEPTH];
  col_t            col_mem [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            accept, wr_en, rd_en, cull;

  // Ready only depends on occupancy and reset, never on upstream data/valid.
  assign halt_RnnnnL   = rst & (count_q < CW'(DEPTH));
  assign validTri_R11H = (count_q != '0);
  assign count_R11U    = count_q;

  // Head entry falls through; zeroed when the FIFO is empty.
  always_comb begin
    tri_R11S   = '0;
    color_R11U = '0;
    if (validTri_R11H) begin
      tri_R11S   = tri_mem[rd_ptr_q];
      color_R11U = col_mem[rd_ptr_q];
    end
  end

`ifdef RAST_TRI_CULL_EN
  localparam int DW = SIGFIG + 1;
  localparam int MW = 2 * SIGFIG + 2;
  localparam int AW = 2 * SIGFIG + 3;

  logic signed [DW-1:0] dx1, dy1, dx2, dy2;
  logic signed [MW-1:0] p_a, p_b;
  logic signed [AW-1:0] area;
  logic [15:0]          culled_q, culled_d;

  // Sign-extend by one bit before subtracting so the difference never overflows.
  function automatic logic signed [DW-1:0] dsub(input logic [SIGFIG-1:0] a,
                                                input logic [SIGFIG-1:0] b);
    return $signed({a[SIGFIG-1], a}) - $signed({b[SIGFIG-1], b});
  endfunction

  // Twice the signed area of the incoming triangle, exact at full width.
  always_comb begin
    dx1  = dsub(tri_R10S[1][0], tri_R10S[0][0]);
    dy1  = dsub(tri_R10S[1][1], tri_R10S[0][1]);
    dx2  = dsub(tri_R10S[2][0], tri_R10S[0][0]);
    dy2  = dsub(tri_R10S[2][1], tri_R10S[0][1]);
    p_a  = $signed({{(MW-DW){dx1[DW-1]}}, dx1}) * $signed({{(MW-DW){dy2[DW-1]}}, dy2});
    p_b  = $signed({{(MW-DW){dx2[DW-1]}}, dx2}) * $signed({{(MW-DW){dy1[DW-1]}}, dy1});
    area = $signed({p_a[MW-1], p_a}) - $signed({p_b[MW-1], p_b});
    cull = (area == '0);
  end

  // Saturating count of accepted-but-dropped degenerate triangles.
  always_comb begin
    culled_d = culled_q;
    if (accept && cull && (culled_q != 16'hFFFF)) culled_d = culled_q + 16'd1;
  end

  // Cull counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) culled_q <= '0;
    else      culled_q <= culled_d;
  end

  assign culled_cnt_RnnnnU = culled_q;
`else
  assign cull              = 1'b0;
  assign culled_cnt_RnnnnU = '0;
`endif

  // Handshake decode and next-state for pointers/occupancy; pointers wrap mod DEPTH.
  always_comb begin
    accept   = validTri_R10H & halt_RnnnnL;
    wr_en    = accept & ~cull;
    rd_en    = validTri_R11H & halt_R11L;
    wr_ptr_d = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(wr_en) - CW'(rd_en);
  end

  // Pointer and occupancy registers; reset discards all entries at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents need no reset since validity comes from count.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tri_mem[wr_ptr_q] <= tri_R10S;
      col_mem[wr_ptr_q] <= color_R10U;
    end
  end

endmodule

// File: tb/tb_rast_tri_fifo.sv
// tb_rast_tri_fifo: directed checks of rast_tri_fifo at default parameters.
module tb_rast_tri_fifo;
  localparam int S = 24;

  logic                          clk, rst;
  logic signed [2:0][2:0][S-1:0] tri_i, tri_o;
  logic        [2:0][S-1:0]      col_i, col_o;
  logic                          vld_i, vld_o, halt_up, halt_dn;
  logic        [2:0]             count;
  logic        [15:0]            culled;

  int checks = 0;
  int errors = 0;

  rast_tri_fifo dut (
    .clk(clk), .rst(rst),
    .tri_R10S(tri_i), .color_R10U(col_i), .validTri_R10H(vld_i),
    .halt_RnnnnL(halt_up),
    .tri_R11S(tri_o), .color_R11U(col_o), .validTri_R11H(vld_o),
    .halt_R11L(halt_dn), .count_R11U(count), .culled_cnt_RnnnnU(culled)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [287:0] act, input logic [287:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Non-degenerate triangle tagged by base B (area 0x10000).
  function automatic logic [215:0] tri_of(input logic [S-1:0] b);
    logic [2:0][2:0][S-1:0] t;
    t[0][0] = b;            t[0][1] = b + 24'd1;     t[0][2] = b + 24'd2;
    t[1][0] = b + 24'h100;  t[1][1] = b + 24'd1;     t[1][2] = b + 24'd3;
    t[2][0] = b;            t[2][1] = b + 24'h101;   t[2][2] = b + 24'd4;
    return t;
  endfunction

  function automatic logic [71:0] col_of(input logic [S-1:0] b);
    return {b ^ 24'hFFFFFF, b + 24'd5, b + 24'd6};
  endfunction

  function automatic logic [287:0] ent_of(input logic [S-1:0] b);
    return {tri_of(b), col_of(b)};
  endfunction

  task automatic drive(input logic [S-1:0] b);
    tri_i = tri_of(b);
    col_i = col_of(b);
    vld_i = 1'b1;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  logic [S-1:0] seq [10];

  initial begin
    rst = 1'b0; vld_i = 1'b0; halt_dn = 1'b0; tri_i = '0; col_i = '0;
    step(); step();
    chk("rst_count", count, 0);
    chk("rst_vld", vld_o, 0);
    chk("rst_halt", halt_up, 0);
    chk("rst_culled", culled, 0);
    chk("rst_data", {tri_o, col_o}, 0);
    rst = 1'b1;
    #1;
    chk("rel_halt", halt_up, 1);

    // Empty FIFO: one-cycle fall-through then drain, then pop on empty.
    drive(24'h000400); halt_dn = 1'b1;
    step();
    vld_i = 1'b0;
    chk("e_vld", vld_o, 1);
    chk("e_x0", tri_o[0][0], 24'h000400);
    chk("e_ent", {tri_o, col_o}, ent_of(24'h000400));
    chk("e_cnt1", count, 1);
    step();
    chk("e_cnt0", count, 0);
    chk("e_vld0", vld_o, 0);
    chk("e_zero", {tri_o, col_o}, 0);
    step();
    chk("e_underflow", count, 0);

    // Full: five back-to-back pushes with downstream stalled.
    halt_dn = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      drive(24'(k * 32'h1000));
      step();
    end
    chk("f_cnt4", count, 4);
    chk("f_halt0", halt_up, 0);
    drive(24'h005000);
    step();
    chk("f_held_cnt", count, 4);
    chk("f_head", {tri_o, col_o}, ent_of(24'h001000));
    halt_dn = 1'b1;
    step();
    chk("f_pop_cnt", count, 3);
    chk("f_halt1", halt_up, 1);
    chk("f_out2", {tri_o, col_o}, ent_of(24'h002000));
    step();
    vld_i = 1'b0;
    chk("f_pp_cnt", count, 3);
    for (int k = 3; k <= 5; k++) begin
      chk("f_order", {tri_o, col_o}, ent_of(24'(k * 32'h1000)));
      step();
    end
    chk("f_empty", count, 0);

    // Simultaneous push/pop at count 2.
    halt_dn = 1'b0;
    drive(24'h0A0000); step();
    drive(24'h0B0000); step();
    chk("s_cnt2", count, 2);
    drive(24'h0C0000); halt_dn = 1'b1;
    step();
    vld_i = 1'b0;
    chk("s_cnt_same", count, 2);
    chk("s_out_b", {tri_o, col_o}, ent_of(24'h0B0000));
    step();
    chk("s_out_c", {tri_o, col_o}, ent_of(24'h0C0000));
    chk("s_cnt1", count, 1);
    step();
    chk("s_empty", count, 0);

    // Wrap: ten triangles through with downstream toggling every cycle.
    for (int k = 0; k < 10; k++) seq[k] = 24'(32'h100000 + k * 32'h10203);
    begin
      int wi, wj, cyc;
      logic h, do_push;
      wi = 0; wj = 0; cyc = 0; h = 1'b0;
      while (wj < 10 && cyc < 200) begin
        halt_dn = h;
        if (wi < 10) drive(seq[wi]);
        else vld_i = 1'b0;
        #1;
        do_push = vld_i & halt_up;
        if (vld_o && h) begin
          chk("w_order", {tri_o, col_o}, ent_of(seq[wj]));
          wj++;
        end
        step();
        if (do_push) wi++;
        h = ~h;
        cyc++;
      end
      chk("w_done", wj, 10);
    end
    vld_i = 1'b0; halt_dn = 1'b0;
    chk("w_empty", count, 0);

    // Asynchronous reset mid-cycle with three entries held.
    for (int k = 0; k < 3; k++) begin
      drive(24'(32'h200000 + k)); step();
    end
    vld_i = 1'b0;
    chk("r_cnt3", count, 3);
    #3 rst = 1'b0;
    #1;
    chk("r_vld", vld_o, 0);
    chk("r_halt", halt_up, 0);
    chk("r_cnt", count, 0);
    step();
    rst = 1'b1;
    #1;
    chk("r_rel_halt", halt_up, 1);
    chk("r_rel_vld", vld_o, 0);

    // Degenerate (collinear) triangle.
    tri_i = '0;
    tri_i[1][0] = 24'h400; tri_i[1][1] = 24'h400;
    tri_i[2][0] = 24'h800; tri_i[2][1] = 24'h800;
    col_i = '0; vld_i = 1'b1; halt_dn = 1'b0;
    step();
    vld_i = 1'b0;
`ifdef RAST_TRI_CULL_EN
    chk("c_vld", vld_o, 0);
    chk("c_cnt", count, 0);
    chk("c_culled", culled, 1);
`else
    chk("c_vld", vld_o, 1);
    chk("c_cnt", count, 1);
    chk("c_x2", tri_o[2][0], 24'h800);
    chk("c_culled", culled, 0);
`endif
    halt_dn = 1'b1;
    step();
    chk("c_drain", count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
